// File: rtl/step_sequencer.sv
// Step-pulse sequencer: acceleration-limited step period ramp with direction setup and no truncated pulses.
// Build macro STEP_SEQ_RAMP_EN enables the period ramp; undefined jumps straight to the target period.
module step_sequencer #(
  parameter int unsigned WIDTH_WORK  = 16,
  parameter int unsigned PULSE_WIDTH = 100,
  parameter int unsigned DIR_SETUP   = 250,
  parameter int unsigned PERIOD_MAX  = 32'h0000_FFFF,
  parameter int unsigned RAMP_STEP   = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  dir_req,
  input  logic [WIDTH_WORK-1:0] period_req,
  output logic                  drv_step,
  output logic                  drv_dir,
  output logic                  busy,
  output logic [WIDTH_WORK-1:0] step_count,
  output logic [WIDTH_WORK-1:0] period_cur
);

`ifdef STEP_SEQ_RAMP_EN
  localparam bit RAMP_EN = 1'b1;
`else
  localparam bit RAMP_EN = 1'b0;
`endif

  localparam int unsigned           WX         = WIDTH_WORK + 1;
  localparam logic [WX-1:0]         PMAX_X     = WX'(PERIOD_MAX);
  localparam logic [WX-1:0]         RAMP_X     = WX'(RAMP_STEP);
  localparam logic [WX-1:0]         PMIN_X     = WX'(2 * PULSE_WIDTH);
  localparam logic [WIDTH_WORK-1:0] PW_W       = WIDTH_WORK'(PULSE_WIDTH);
  localparam logic [WIDTH_WORK-1:0] SETUP_LOAD = WIDTH_WORK'(DIR_SETUP - 1);
  localparam logic [WIDTH_WORK-1:0] ONE_W      = WIDTH_WORK'(1);

  typedef enum logic [1:0] {S_IDLE, S_DIR_SETUP, S_RUN, S_DECEL} state_e;

  state_e                state_q, state_d;
  logic [WIDTH_WORK-1:0] phase_q, phase_d;
  logic [WIDTH_WORK-1:0] setup_q, setup_d;
  logic [WIDTH_WORK-1:0] period_q, period_d;
  logic [WIDTH_WORK-1:0] count_q, count_d;
  logic                  step_q, step_d;
  logic                  dir_q, dir_d;
  logic                  busy_q, busy_d;

  logic                  go_c, same_dir_c, boundary_c, start_c;
  logic [WX-1:0]         req_x, tgt_x, per_x, up_x, ramp_x, decel_x, entry_x;

  assign go_c       = enable && (period_req != '0);
  assign same_dir_c = (dir_req == dir_q);
  assign boundary_c = (phase_q == (period_q - ONE_W));
  assign req_x      = {1'b0, period_req};
  assign tgt_x      = (req_x > PMIN_X) ? req_x : PMIN_X;
  assign per_x      = {1'b0, period_q};
  assign up_x       = per_x + RAMP_X;
  assign decel_x    = (up_x > PMAX_X) ? PMAX_X : up_x;
  assign entry_x    = RAMP_EN ? PMAX_X : tgt_x;

  // Next ramp period toward the target; floors at tgt going down, clamps at tgt going up.
  always_comb begin
    ramp_x = per_x;
    if (!RAMP_EN) begin
      ramp_x = tgt_x;
    end else if (per_x > tgt_x) begin
      ramp_x = (per_x >= (tgt_x + RAMP_X)) ? (per_x - RAMP_X) : tgt_x;
    end else if (per_x < tgt_x) begin
      ramp_x = (up_x > tgt_x) ? tgt_x : up_x;
    end
  end

  // Next-state and datapath; every RUN/DECEL change waits for the period boundary.
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    setup_d  = setup_q;
    period_d = period_q;
    dir_d    = dir_q;
    start_c  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (go_c && same_dir_c) begin
          state_d  = S_RUN;
          start_c  = 1'b1;
          period_d = WIDTH_WORK'(entry_x);
        end else if (go_c) begin
          dir_d   = dir_req;
          setup_d = SETUP_LOAD;
          state_d = S_DIR_SETUP;
        end
      end
      S_DIR_SETUP: begin
        if (!go_c) begin
          state_d = S_IDLE;
        end else if (setup_q == '0) begin
          state_d  = S_RUN;
          start_c  = 1'b1;
          period_d = WIDTH_WORK'(entry_x);
        end else begin
          setup_d = setup_q - ONE_W;
        end
      end
      S_RUN: begin
        if (boundary_c) begin
          start_c = 1'b1;
          if (!go_c || !same_dir_c) begin
            state_d = S_DECEL;
          end else begin
            period_d = WIDTH_WORK'(ramp_x);
          end
        end else begin
          phase_d = phase_q + ONE_W;
        end
      end
      S_DECEL: begin
        if (boundary_c) begin
          if (go_c && same_dir_c) begin
            state_d = S_RUN;
            start_c = 1'b1;
            if (!RAMP_EN) period_d = WIDTH_WORK'(tgt_x);
          end else if (!RAMP_EN || (per_x == PMAX_X)) begin
            state_d = S_IDLE;
          end else begin
            start_c  = 1'b1;
            period_d = WIDTH_WORK'(decel_x);
          end
        end else begin
          phase_d = phase_q + ONE_W;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (start_c) phase_d = '0;
    count_d = start_c ? (count_q + ONE_W) : count_q;
    step_d  = ((state_d == S_RUN) || (state_d == S_DECEL)) && (phase_d < PW_W);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      phase_q  <= '0;
      setup_q  <= '0;
      period_q <= WIDTH_WORK'(PERIOD_MAX);
      count_q  <= '0;
      step_q   <= 1'b0;
      dir_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      setup_q  <= setup_d;
      period_q <= period_d;
      count_q  <= count_d;
      step_q   <= step_d;
      dir_q    <= dir_d;
      busy_q   <= busy_d;
    end
  end

  assign drv_step   = step_q;
  assign drv_dir    = dir_q;
  assign busy       = busy_q;
  assign step_count = count_q;
  assign period_cur = period_q;

endmodule
